// File: rtl/output_serializer.sv
// Streams one NUM_CH-word result vector from core to the writer, channel 0 first.
// Define SER_CHECKSUM_EN to append an XOR checksum word after the last channel.
module output_serializer #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CH     = 255,
   parameter int IDX_W      = 8
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
   input  logic                         valid_in,
   input  logic                         empty,
   output logic                         rd_en,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         valid_out,
   input  logic                         ready_in,
   output logic                         last_out,
   output logic [IDX_W-1:0]             ch_idx,
   output logic [15:0]                  frame_cnt,
   output logic                         drop_err
);

`ifdef SER_CHECKSUM_EN
   localparam int N_WORDS = NUM_CH + 1;
`else
   localparam int N_WORDS = NUM_CH;
`endif
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      SEND
   } state_t;

   state_t                         state;
   logic [NUM_CH*DATA_WIDTH-1:0]   shadow;
   logic [DATA_WIDTH-1:0]          words [NUM_CH];
   logic [IDX_W-1:0]               nxt_idx;
   logic [DATA_WIDTH-1:0]          nxt_word;
   logic                           accept;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         words[i] = shadow[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

`ifdef SER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] csum;

   always_comb begin
      csum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         csum = csum ^ words[i];
      end
   end
`endif

   // Word presented after the current one is accepted.
   always_comb begin
      nxt_idx  = ch_idx + 1'b1;
      nxt_word = '0;
      if (int'(nxt_idx) < NUM_CH) begin
         nxt_word = words[nxt_idx];
      end
`ifdef SER_CHECKSUM_EN
      else begin
         nxt_word = csum;
      end
`endif
   end

   assign accept = valid_out & ready_in;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state     <= IDLE;
         rd_en     <= 1'b0;
         valid_out <= 1'b0;
         last_out  <= 1'b0;
         data_out  <= '0;
         ch_idx    <= '0;
         frame_cnt <= '0;
         drop_err  <= 1'b0;
         shadow    <= '0;
      end else begin
         if (valid_in && state != WAIT) begin
            drop_err <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (!empty) begin
                  rd_en <= 1'b1;
                  state <= WAIT;
               end else begin
                  rd_en <= 1'b0;
               end
            end
            WAIT: begin
               rd_en <= 1'b0;
               if (valid_in) begin
                  shadow    <= data_in;
                  ch_idx    <= '0;
                  data_out  <= data_in[DATA_WIDTH-1:0];
                  last_out  <= (LAST_IDX == '0);
                  valid_out <= 1'b1;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (accept) begin
                  if (ch_idx == LAST_IDX) begin
                     frame_cnt <= frame_cnt + 16'd1;
                     valid_out <= 1'b0;
                     last_out  <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     ch_idx   <= nxt_idx;
                     data_out <= nxt_word;
                     last_out <= (nxt_idx == LAST_IDX);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
